// File: rtl/cache_refill_pkg.sv
// cache_refill_pkg: FSM state encodings and default widths shared by the refill path and the cache.
package cache_refill_pkg;
    localparam int XLEN_DEF = 32;
    localparam int BYTE_OFFSET_DEF = 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM_REQ = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;
endpackage

// File: rtl/cache_refill_if.sv
// cache_refill_if: CPU, cache lookup/update and memory bus signals of the refill block; slave is the block itself.
interface cache_refill_if import cache_refill_pkg::*; #(parameter int XLEN = XLEN_DEF);
    logic            req_valid, req_ready, req_we;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic [XLEN-1:0] cache_addr, cache_data;
    logic            cache_hit;
    logic            update;
    logic [XLEN-1:0] update_addr, update_data;
    logic            mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, cache_hit, cache_data, mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_data, cache_addr, update, update_addr, update_data,
               mem_valid, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, cache_hit, cache_data, mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_data, cache_addr, update, update_addr, update_data,
               mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_refill.sv
// cache_refill: single-outstanding miss handler, write-through/write-allocate, with update-bus forwarding.
// Define CACHE_REFILL_STATS_EN to add hit_count/miss_count load counters.
module cache_refill import cache_refill_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int BYTE_OFFSET = BYTE_OFFSET_DEF
) (
    input logic clk,
    input logic rst,
    cache_refill_if.slave bus
`ifdef CACHE_REFILL_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, resp_data_q, resp_data_d;
    logic [XLEN-1:0] update_addr_q, update_addr_d, update_data_q, update_data_d;
    logic            we_q, we_d, resp_valid_q, resp_valid_d, update_q, update_d;
    logic            accept, fwd, hit;
    logic [XLEN-1:0] req_word, hit_data;

    assign req_word = {bus.req_addr[XLEN-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
    assign accept = bus.req_valid && state_q == IDLE;
    // The cache sees an update one edge late, so a word being written this cycle is served from the update bus.
    assign fwd = update_q && req_word == update_addr_q;
    assign hit = fwd || bus.cache_hit;
    assign hit_data = fwd ? update_data_q : bus.cache_data;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        we_d = we_q;
        resp_valid_d = 1'b0;
        resp_data_d = resp_data_q;
        update_d = 1'b0;
        update_addr_d = update_addr_q;
        update_data_d = update_data_q;
        case (state_q)
            IDLE: if (accept) begin
                if (bus.req_we || !hit) begin
                    state_d = MEM_REQ;
                    addr_d = req_word;
                    we_d = bus.req_we;
                    wdata_d = bus.req_we ? bus.req_wdata : '0;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_data_d = hit_data;
                end
            end
            MEM_REQ: if (bus.mem_ready) begin
                state_d = we_q ? IDLE : MEM_WAIT;
                if (we_q) begin
                    resp_valid_d = 1'b1;
                    resp_data_d = '0;
                    update_d = 1'b1;
                    update_addr_d = addr_q;
                    update_data_d = wdata_q;
                end
            end
            MEM_WAIT: if (bus.mem_rvalid) begin
                state_d = IDLE;
                resp_valid_d = 1'b1;
                resp_data_d = bus.mem_rdata;
                update_d = 1'b1;
                update_addr_d = addr_q;
                update_data_d = bus.mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q <= '0;
            update_q <= 1'b0;
            update_addr_q <= '0;
            update_data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            we_q <= we_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q <= resp_data_d;
            update_q <= update_d;
            update_addr_q <= update_addr_d;
            update_data_q <= update_data_d;
        end
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data = resp_data_q;
    assign bus.cache_addr = state_q == IDLE ? bus.req_addr : addr_q;
    assign bus.update = update_q;
    assign bus.update_addr = update_addr_q;
    assign bus.update_data = update_data_q;
    assign bus.mem_valid = state_q == MEM_REQ;
    assign bus.mem_we = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wdata = wdata_q;

`ifdef CACHE_REFILL_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d = hit_count_q + {31'd0, accept && !bus.req_we && hit};
        miss_count_d = miss_count_q + {31'd0, accept && !bus.req_we && !hit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: directed scenarios for cache_refill against a small direct-mapped cache model.
module tb_cache_refill;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    cache_refill_if #(.XLEN(32)) bus();

`ifdef CACHE_REFILL_STATS_EN
    logic [31:0] hit_count, miss_count;
    cache_refill dut (.clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
    cache_refill dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Cache model: fixed entry 0x100 plus four update-written lines indexed by addr[9:8].
    logic [3:0]  c_v = '0;
    logic [31:0] c_tag [4];
    logic [31:0] c_dat [4];
    always @(posedge clk) begin
        if (bus.update) begin
            c_v[bus.update_addr[9:8]] <= 1'b1;
            c_tag[bus.update_addr[9:8]] <= bus.update_addr;
            c_dat[bus.update_addr[9:8]] <= bus.update_data;
        end
    end
    always_comb begin
        bus.cache_hit = 1'b0;
        bus.cache_data = '0;
        if (bus.cache_addr == 32'h100) begin
            bus.cache_hit = 1'b1;
            bus.cache_data = 32'hDEADBEEF;
        end
        if (c_v[bus.cache_addr[9:8]] && c_tag[bus.cache_addr[9:8]] == bus.cache_addr) begin
            bus.cache_hit = 1'b1;
            bus.cache_data = c_dat[bus.cache_addr[9:8]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %0b want 0", bus.resp_valid); end
        n_tests++; if (bus.update !== 1'b0) begin n_fail++; $display("FAIL reset_update got %0b want 0", bus.update); end
        n_tests++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %0b want 0", bus.mem_valid); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0b want 0", bus.mem_we); end
        n_tests++; if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
        n_tests++; if ({bus.resp_data, bus.update_addr, bus.update_data} !== 96'd0) begin n_fail++; $display("FAIL reset_data got %h/%h/%h want 0", bus.resp_data, bus.update_addr, bus.update_data); end
`ifdef CACHE_REFILL_STATS_EN
        n_tests++; if ({hit_count, miss_count} !== 64'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_hit();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h100;
        #1;
        n_tests++; if (bus.cache_addr !== 32'h100) begin n_fail++; $display("FAIL hit_cache_addr got %h want 00000100", bus.cache_addr); end
        tick();
        bus.req_valid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL hit_resp_valid got %0b want 1", bus.resp_valid); end
        n_tests++; if (bus.resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_resp_data got %h want deadbeef", bus.resp_data); end
        n_tests++; if ({bus.mem_valid, bus.update} !== 2'b00) begin n_fail++; $display("FAIL hit_no_mem got %b want 00", {bus.mem_valid, bus.update}); end
        tick();
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pulse got %0b want 0", bus.resp_valid); end
    endtask

    task automatic test_load_miss();
        int held = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h200;
        tick();
        bus.req_valid = 1'b0; bus.req_addr = 32'hFFF0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_valid === 1'b1 && bus.mem_addr === 32'h200 && bus.mem_we === 1'b0 && bus.cache_addr === 32'h200) held++;
            bus.mem_ready = (i == 3);
            tick();
            bus.mem_rvalid = 1'b0;
        end
        bus.mem_ready = 1'b0;
        n_tests++; if (held !== 4) begin n_fail++; $display("FAIL miss_mem_held got %0d want 4", held); end
        n_tests++; if ({bus.mem_valid, bus.resp_valid, bus.update} !== 3'b000) begin n_fail++; $display("FAIL miss_wait_idle got %b want 000", {bus.mem_valid, bus.resp_valid, bus.update}); end
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_rvalid = 1'b0;
        n_tests++; if ({bus.resp_valid, bus.update, bus.req_ready} !== 3'b111) begin n_fail++; $display("FAIL miss_resp_update got %b want 111", {bus.resp_valid, bus.update, bus.req_ready}); end
        n_tests++; if (bus.resp_data !== 32'h12345678) begin n_fail++; $display("FAIL miss_resp_data got %h want 12345678", bus.resp_data); end
        n_tests++; if ({bus.update_addr, bus.update_data} !== {32'h200, 32'h12345678}) begin n_fail++; $display("FAIL miss_update got %h/%h want 00000200/12345678", bus.update_addr, bus.update_data); end
        tick();
        n_tests++; if ({bus.resp_valid, bus.update} !== 2'b00) begin n_fail++; $display("FAIL miss_pulse got %b want 00", {bus.resp_valid, bus.update}); end
    endtask

    task automatic test_unaligned();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h203;
        tick();
        bus.req_valid = 1'b0;
        n_tests++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL unal_mem_addr got %0b/%h want 1/00000200", bus.mem_valid, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADCAFE;
        tick();
        bus.mem_rvalid = 1'b0;
        n_tests++; if ({bus.update, bus.update_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL unal_update_addr got %0b/%h want 1/00000200", bus.update, bus.update_addr); end
        n_tests++; if (bus.resp_data !== 32'h0BADCAFE) begin n_fail++; $display("FAIL unal_resp_data got %h want 0badcafe", bus.resp_data); end
        tick();
    endtask

    task automatic test_store();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h300; bus.req_wdata = 32'hCAFEF00D;
        tick();
        bus.req_valid = 1'b0;
        n_tests++; if ({bus.mem_valid, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL store_mem_we got %b want 11", {bus.mem_valid, bus.mem_we}); end
        n_tests++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h300, 32'hCAFEF00D}) begin n_fail++; $display("FAIL store_mem_bus got %h/%h want 00000300/cafef00d", bus.mem_addr, bus.mem_wdata); end
        tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n_tests++; if ({bus.resp_valid, bus.update, bus.mem_valid, bus.req_ready} !== 4'b1101) begin n_fail++; $display("FAIL store_done got %b want 1101", {bus.resp_valid, bus.update, bus.mem_valid, bus.req_ready}); end
        n_tests++; if ({bus.update_addr, bus.update_data, bus.resp_data} !== {32'h300, 32'hCAFEF00D, 32'h0}) begin n_fail++; $display("FAIL store_update got %h/%h/%h want 00000300/cafef00d/00000000", bus.update_addr, bus.update_data, bus.resp_data); end
        tick();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h100; bus.req_wdata = 32'h11111111;
        tick();
        bus.req_valid = 1'b0;
        n_tests++; if ({bus.mem_valid, bus.resp_valid} !== 2'b10) begin n_fail++; $display("FAIL store_hit_ignored got %b want 10", {bus.mem_valid, bus.resp_valid}); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n_tests++; if ({bus.update, bus.update_data} !== {1'b1, 32'h11111111}) begin n_fail++; $display("FAIL store_hit_update got %0b/%h want 1/11111111", bus.update, bus.update_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        int mv = 0;
`ifdef CACHE_REFILL_STATS_EN
        logic [31:0] h0, m0;
        h0 = hit_count; m0 = miss_count;
`endif
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h400;
        tick();
        bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h4444AAAA;
        tick();
        bus.mem_rvalid = 1'b0;
        n_tests++; if ({bus.update, bus.resp_valid, bus.req_ready, bus.cache_hit} !== 4'b1110) begin n_fail++; $display("FAIL b2b_update_cycle got %b want 1110", {bus.update, bus.resp_valid, bus.req_ready, bus.cache_hit}); end
        bus.req_valid = 1'b1; bus.req_addr = 32'h400;
        tick();
        bus.req_valid = 1'b0;
        n_tests++; if ({bus.resp_valid, bus.resp_data} !== {1'b1, 32'h4444AAAA}) begin n_fail++; $display("FAIL b2b_forward got %0b/%h want 1/4444aaaa", bus.resp_valid, bus.resp_data); end
        for (int i = 0; i < 3; i++) begin
            if (bus.mem_valid !== 1'b0 || bus.update !== 1'b0) mv++;
            tick();
        end
        n_tests++; if (mv !== 0) begin n_fail++; $display("FAIL b2b_no_refill got %0d busy cycles want 0", mv); end
`ifdef CACHE_REFILL_STATS_EN
        n_tests++; if ({hit_count - h0, miss_count - m0} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL b2b_counts got hit+%0d miss+%0d want +1/+1", hit_count - h0, miss_count - m0); end
`endif
    endtask

    task automatic test_async_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h500;
        tick();
        bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n_tests++; if ({bus.req_ready, bus.mem_valid, bus.mem_addr} !== {2'b00, 32'h500}) begin n_fail++; $display("FAIL areset_in_wait got %b/%h want 00/00000500", {bus.req_ready, bus.mem_valid}, bus.mem_addr); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({bus.req_ready, bus.mem_valid, bus.mem_we, bus.resp_valid, bus.update} !== 5'b10000) begin n_fail++; $display("FAIL areset_ctrl got %b want 10000", {bus.req_ready, bus.mem_valid, bus.mem_we, bus.resp_valid, bus.update}); end
        n_tests++; if ({bus.mem_addr, bus.cache_addr, bus.update_addr} !== 96'd0) begin n_fail++; $display("FAIL areset_addr got %h/%h/%h want 0", bus.mem_addr, bus.cache_addr, bus.update_addr); end
        tick();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55555555;
        tick();
        bus.mem_rvalid = 1'b0;
        n_tests++; if ({bus.resp_valid, bus.update} !== 2'b00) begin n_fail++; $display("FAIL areset_stale_rvalid got %b want 00", {bus.resp_valid, bus.update}); end
        bus.req_valid = 1'b1; bus.req_addr = 32'h100;
        tick();
        bus.req_valid = 1'b0;
        n_tests++; if ({bus.resp_valid, bus.resp_data, bus.mem_valid} !== {1'b1, 32'h11111111, 1'b0}) begin n_fail++; $display("FAIL areset_next_req got %0b/%h/%0b want 1/11111111/0", bus.resp_valid, bus.resp_data, bus.mem_valid); end
`ifdef CACHE_REFILL_STATS_EN
        n_tests++; if ({hit_count, miss_count} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL areset_counts got %0d/%0d want 1/0", hit_count, miss_count); end
`endif
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        #1 rst = 1'b1;
        test_reset();
        test_load_hit();
        test_load_miss();
        test_unaligned();
        test_store();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
